// File: rtl/daisy_pkg.sv
// Shared constants and types for the daisy-chain link.
// The TX side uses the same nibble width and training word.
package daisy_pkg;

    localparam int unsigned NIB_W         = 4;
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned SLIP_WAIT_CYC = 4;

    localparam logic [WORD_W-1:0] TRAIN_PAT_DEF = 16'h00FF;

    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StSlipWait,
        StLocked
    } rx_state_e;

endpackage

// File: rtl/daisy_rx_word_asm.sv
// Nibble-to-word assembler: shift register, nibble counter with slip, word boundary strobe.
// The first nibble received lands in word bits [3:0].
module daisy_rx_word_asm
    import daisy_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NIB_W-1:0]  nib_i,
    input  logic              slip_i,
    output logic [WORD_W-1:0] word_o,
    output logic              boundary_o
);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [1:0]        nib_cnt_q, nib_cnt_d;

    always_comb begin
        sr_d      = {nib_i, sr_q[WORD_W-1:NIB_W]};
        // Holding the count for one cycle pushes the word boundary one nibble later.
        nib_cnt_d = slip_i ? nib_cnt_q : nib_cnt_q + 2'd1;
    end

    // Pure data path, left unreset so it keeps filling while reset is held.
    always_ff @(posedge clk_i) begin
        sr_q <= sr_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            nib_cnt_q <= '0;
        end else begin
            nib_cnt_q <= nib_cnt_d;
        end
    end

    assign word_o     = sr_q;
    assign boundary_o = (nib_cnt_q == 2'd3);

endmodule

// File: rtl/red_pitaya_daisy_rx_align.sv
// Daisy-chain RX aligner: hunts bit and nibble alignment on a training word, then delivers words.
// Defining DAISY_RX_ERRCNT_EN adds err_cnt_o, a saturating count of training misses while locked.
module red_pitaya_daisy_rx_align
    import daisy_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PAT = TRAIN_PAT_DEF,
    parameter int unsigned       MATCH_CNT = 4,
    parameter int unsigned       TRY_WORDS = 8,
    parameter int unsigned       MISS_MAX  = 3
) (
    input  logic              par_clk_i,
    input  logic              par_rstn_i,
    input  logic              sync_mode_i,
    input  logic [NIB_W-1:0]  ser_nib_i,
    output logic              bitslip_o,
    input  logic              cfg_train_i,
    output logic              lock_o,
    output logic              par_dv_o,
    output logic [WORD_W-1:0] par_dat_o
`ifdef DAISY_RX_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt_o
`endif
);

    logic [WORD_W-1:0] word;
    logic              boundary;
    logic              word_hit;
    logic              word_nz;
    logic              lock_miss;

    rx_state_e         state_q, state_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [3:0]        try_cnt_q, try_cnt_d;
    logic [3:0]        miss_cnt_q, miss_cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              bitslip_q, bitslip_d;
    logic              slip_q, slip_d;
    logic              lock_q, lock_d;
    logic              dv_q, dv_d;
    logic [WORD_W-1:0] dat_q, dat_d;

    daisy_rx_word_asm u_word_asm (
        .clk_i      (par_clk_i),
        .rst_ni     (par_rstn_i),
        .nib_i      (ser_nib_i),
        .slip_i     (slip_q),
        .word_o     (word),
        .boundary_o (boundary)
    );

    assign word_hit  = (word == TRAIN_PAT);
    assign word_nz   = |word;
    assign lock_miss = !sync_mode_i && (state_q == StLocked) && cfg_train_i && boundary && !word_hit;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        try_cnt_d   = try_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        phase_d     = phase_q;
        wait_cnt_d  = wait_cnt_q;
        bitslip_d   = 1'b0;
        slip_d      = 1'b0;
        dv_d        = 1'b0;
        dat_d       = dat_q;
        lock_d      = lock_q;

        if (sync_mode_i) begin
            // Raw passthrough; the alignment FSM is frozen where it stands.
            dat_d  = {{(WORD_W-NIB_W){1'b0}}, ser_nib_i};
            dv_d   = 1'b1;
            lock_d = 1'b1;
        end else begin
            if (boundary && word_nz) begin
                dat_d = word;
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_train_i) begin
                        state_d = StHunt;
                    end
                end

                StHunt: begin
                    if (!cfg_train_i) begin
                        state_d     = StIdle;
                        match_cnt_d = '0;
                        try_cnt_d   = '0;
                        phase_d     = '0;
                    end else if (boundary) begin
                        if (word_hit) begin
                            if (match_cnt_q == 4'(MATCH_CNT - 1)) begin
                                state_d     = StLocked;
                                match_cnt_d = '0;
                                try_cnt_d   = '0;
                                miss_cnt_d  = '0;
                            end else begin
                                match_cnt_d = match_cnt_q + 4'd1;
                            end
                        end else begin
                            match_cnt_d = '0;
                            if (try_cnt_q == 4'(TRY_WORDS - 1)) begin
                                try_cnt_d = '0;
                                if (phase_q == 2'd3) begin
                                    phase_d    = '0;
                                    bitslip_d  = 1'b1;
                                    wait_cnt_d = '0;
                                    state_d    = StSlipWait;
                                end else begin
                                    phase_d = phase_q + 2'd1;
                                    slip_d  = 1'b1;
                                end
                            end else begin
                                try_cnt_d = try_cnt_q + 4'd1;
                            end
                        end
                    end
                end

                StSlipWait: begin
                    if (wait_cnt_q == 3'(SLIP_WAIT_CYC - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = cfg_train_i ? StHunt : StIdle;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 3'd1;
                    end
                end

                StLocked: begin
                    if (cfg_train_i) begin
                        if (boundary && word_hit) begin
                            miss_cnt_d = '0;
                        end else if (lock_miss) begin
                            if (miss_cnt_q == 4'(MISS_MAX - 1)) begin
                                miss_cnt_d = '0;
                                state_d    = StHunt;
                            end else begin
                                miss_cnt_d = miss_cnt_q + 4'd1;
                            end
                        end
                    end else if (boundary && word_nz) begin
                        dv_d = 1'b1;
                    end
                end

                default: state_d = StIdle;
            endcase

            lock_d = (state_d == StLocked);
        end
    end

    always_ff @(posedge par_clk_i) begin
        if (!par_rstn_i) begin
            state_q     <= StIdle;
            match_cnt_q <= '0;
            try_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            phase_q     <= '0;
            wait_cnt_q  <= '0;
            bitslip_q   <= 1'b0;
            slip_q      <= 1'b0;
            lock_q      <= 1'b0;
            dv_q        <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            try_cnt_q   <= try_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            phase_q     <= phase_d;
            wait_cnt_q  <= wait_cnt_d;
            bitslip_q   <= bitslip_d;
            slip_q      <= slip_d;
            lock_q      <= lock_d;
            dv_q        <= dv_d;
            dat_q       <= dat_d;
        end
    end

    assign bitslip_o = bitslip_q;
    assign lock_o    = lock_q;
    assign par_dv_o  = dv_q;
    assign par_dat_o = dat_q;

`ifdef DAISY_RX_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        cfg_train_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cfg_train_i && !cfg_train_q) begin
            err_cnt_d = '0;
        end else if (lock_miss && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge par_clk_i) begin
        if (!par_rstn_i) begin
            err_cnt_q   <= '0;
            cfg_train_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            cfg_train_q <= cfg_train_i;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_red_pitaya_daisy_rx_align.sv
// Directed bench for the daisy RX aligner: a bit-level TX model feeds nibbles, results are
// compared against hand-derived cycle counts and words.
module tb_red_pitaya_daisy_rx_align;

    localparam logic [15:0] TRAIN = 16'h00FF;
    localparam int          MEM_N = 2048;

    logic        par_clk_i = 1'b0;
    logic        par_rstn_i;
    logic        sync_mode_i;
    logic [3:0]  ser_nib_i;
    logic        bitslip_o;
    logic        cfg_train_i;
    logic        lock_o;
    logic        par_dv_o;
    logic [15:0] par_dat_o;
`ifdef DAISY_RX_ERRCNT_EN
    logic [15:0] err_cnt_o;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_n = 0;
    int          noff = 0;
    int          boff = 0;
    int          n_bitslip = 0;
    int          bs_edge = -1;
    logic        raw_mode = 1'b0;
    logic [3:0]  raw_nib = 4'h0;
    logic [15:0] tx_mem [MEM_N];

    always #5 par_clk_i = ~par_clk_i;

    red_pitaya_daisy_rx_align dut (
        .par_clk_i   (par_clk_i),
        .par_rstn_i  (par_rstn_i),
        .sync_mode_i (sync_mode_i),
        .ser_nib_i   (ser_nib_i),
        .bitslip_o   (bitslip_o),
        .cfg_train_i (cfg_train_i),
        .lock_o      (lock_o),
        .par_dv_o    (par_dv_o),
        .par_dat_o   (par_dat_o)
`ifdef DAISY_RX_ERRCNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Nibble seen at a given clock edge: four consecutive bits of the TX bit stream.
    function automatic logic [3:0] tx_nib(input int e);
        logic [3:0]  n;
        logic [15:0] w;
        int          p;
        for (int b = 0; b < 4; b++) begin
            p    = 4 * (e + noff) + boff + b;
            w    = tx_mem[(p / 16) % MEM_N];
            n[b] = w[p % 16];
        end
        return n;
    endfunction

    task automatic step();
        ser_nib_i = raw_mode ? raw_nib : tx_nib(edge_n + 1);
        @(posedge par_clk_i);
        edge_n++;
        #1;
        if (bitslip_o) begin
            n_bitslip++;
            bs_edge = edge_n;
            if (boff > 0) boff--;
        end
    endtask

    // Leaves the last reset edge on a multiple of 4 so stream phase is known.
    task automatic do_reset();
        par_rstn_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        while (edge_n % 4 != 0) step();
        par_rstn_i = 1'b1;
    endtask

    task automatic fill_train();
        for (int i = 0; i < MEM_N; i++) tx_mem[i] = TRAIN;
    endtask

    task automatic run_to_lock(input int limit, output int lk);
        lk = -1;
        for (int i = 0; i < limit && lk < 0; i++) begin
            step();
            if (lock_o) lk = edge_n;
        end
    endtask

    initial begin
        int r;
        int lk;
        int w;
        int j0;
        int n_dv;
        int dv_e [2];
        logic [15:0] dv_w [2];

        par_rstn_i  = 1'b0;
        sync_mode_i = 1'b0;
        cfg_train_i = 1'b1;
        ser_nib_i   = 4'h0;
        fill_train();

        // Aligned training stream
        do_reset();
        r = edge_n;
        check_eq("rst_lock", 32'(lock_o), 32'd0);
        check_eq("rst_dv", 32'(par_dv_o), 32'd0);
        check_eq("rst_dat", 32'(par_dat_o), 32'd0);
        check_eq("rst_bitslip", 32'(bitslip_o), 32'd0);
        for (int i = 0; i < 15; i++) step();
        check_eq("lock_before_16", 32'(lock_o), 32'd0);
        step();
        check_eq("lock_at_16", 32'(lock_o), 32'd1);
        check_eq("dat_at_lock_ph0", 32'(par_dat_o), 32'h00FF);
        check_eq("dv_in_training", 32'(par_dv_o), 32'd0);
        check_eq("bitslip_aligned", 32'(n_bitslip), 32'd0);

        // Locked data delivery: idle, 1234, idle, ABCD, idle
        j0 = edge_n;
        w  = j0 / 4;
        for (int i = 1; i <= 24; i++) tx_mem[w + i] = 16'h0000;
        tx_mem[w + 2] = 16'h1234;
        tx_mem[w + 4] = 16'hABCD;
        for (int i = 0; i < 5; i++) step();
        cfg_train_i = 1'b0;
        n_dv = 0;
        dv_e[0] = -1; dv_e[1] = -1; dv_w[0] = '0; dv_w[1] = '0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (par_dv_o) begin
                if (n_dv < 2) begin
                    dv_e[n_dv] = edge_n - j0;
                    dv_w[n_dv] = par_dat_o;
                end
                n_dv++;
            end
        end
        check_eq("dv_count", 32'(n_dv), 32'd2);
        check_eq("dv0_edge", 32'(dv_e[0]), 32'd12);
        check_eq("dv0_data", 32'(dv_w[0]), 32'h1234);
        check_eq("dv1_edge", 32'(dv_e[1]), 32'd20);
        check_eq("dv1_data", 32'(dv_w[1]), 32'hABCD);
        check_eq("dat_hold", 32'(par_dat_o), 32'hABCD);
        check_eq("lock_data", 32'(lock_o), 32'd1);

        // Training resumes with three corrupted words
        j0 = edge_n;
        w  = j0 / 4;
        for (int i = 1; i <= 30; i++) tx_mem[w + i] = TRAIN;
        for (int i = 3; i <= 5; i++) tx_mem[w + i] = 16'h00FE;
        for (int i = 0; i < 5; i++) step();
        cfg_train_i = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check_eq("lock_after_2_miss", 32'(lock_o), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check_eq("unlock_after_3_miss", 32'(lock_o), 32'd0);
`ifdef DAISY_RX_ERRCNT_EN
        check_eq("err_cnt", 32'(err_cnt_o), 32'd3);
`endif
        for (int i = 0; i < 16; i++) step();
        check_eq("relock_from_hunt", 32'(lock_o), 32'd1);

        // Nibble offset 2: two nibble slips, no bitslip
        fill_train();
        noff = 2;
        boff = 0;
        do_reset();
        r = edge_n;
        n_bitslip = 0;
        run_to_lock(200, lk);
        check_eq("lock_edge_noff2", 32'(lk - r), 32'd82);
        check_eq("dat_at_lock_noff2", 32'(par_dat_o), 32'h00FF);
        check_eq("bitslip_noff2", 32'(n_bitslip), 32'd0);

        // Bit offset 1: one bitslip after 4 phases x 8 words
        fill_train();
        noff = 0;
        boff = 1;
        do_reset();
        r = edge_n;
        n_bitslip = 0;
        bs_edge = -1;
        run_to_lock(400, lk);
        check_eq("bitslip_edge", 32'(bs_edge - r), 32'd131);
        check_eq("bitslip_count", 32'(n_bitslip), 32'd1);
        check_eq("lock_edge_boff1", 32'(lk - r), 32'd184);
        check_eq("dat_at_lock_boff1", 32'(par_dat_o), 32'h00FF);

        // Hunting with nibble offset 1, then sync bypass, then reset mid-hunt
        fill_train();
        noff = 1;
        boff = 0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check_eq("dat_hunt_word", 32'(par_dat_o), 32'hF00F);
        check_eq("lock_hunt", 32'(lock_o), 32'd0);
        step();
        step();
        sync_mode_i = 1'b1;
        raw_mode    = 1'b1;
        raw_nib     = 4'h5;
        step();
        check_eq("sync_dat_5", 32'(par_dat_o), 32'h0005);
        check_eq("sync_dv_5", 32'(par_dv_o), 32'd1);
        check_eq("sync_lock", 32'(lock_o), 32'd1);
        raw_nib = 4'hA;
        step();
        check_eq("sync_dat_a", 32'(par_dat_o), 32'h000A);
        check_eq("sync_dv_a", 32'(par_dv_o), 32'd1);
        check_eq("sync_bitslip", 32'(bitslip_o), 32'd0);
        sync_mode_i = 1'b0;
        raw_mode    = 1'b0;
        step();
        check_eq("unsync_lock", 32'(lock_o), 32'd0);
        check_eq("unsync_dv", 32'(par_dv_o), 32'd0);
        par_rstn_i = 1'b0;
        step();
        check_eq("midrst_dat", 32'(par_dat_o), 32'd0);
        check_eq("midrst_dv", 32'(par_dv_o), 32'd0);
        check_eq("midrst_lock", 32'(lock_o), 32'd0);
        check_eq("midrst_bitslip", 32'(bitslip_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
